// File: rtl/comp_multiplier.sv
// -----------------------------------------------------------------------------
// comp_multiplier
//
// Purpose:
//   Sequential shift-add multiplier. It captures two WIDTH-bit operands on a
//   start edge and makes one add/shift step per clock edge for WIDTH edges.
//   It then presents the 2*WIDTH-bit product with a registered ready flag.
//
// Configuration:
//   COMP_MULTIPLIER_SIGNED_EN - when defined, the operands are two's complement.
//   Operand magnitudes are captured at start and run through the same unsigned
//   datapath. The product is negated on the DONE-entry edge when the operand
//   signs differ. When undefined, everything is unsigned and there is no sign
//   logic.
//
// Ports:
//   clk          in   1        single clock, rising edge
//   reset        in   1        synchronous active-high reset
//   run          in   1        start request, only looked at in IDLE
//   Multiplicand in   WIDTH    operand A, captured on the start edge
//   Multiplier   in   WIDTH    operand B, captured on the start edge
//   Product      out  2*WIDTH  registered result, valid while ready=1
//   ready        out  1        registered completion flag
// -----------------------------------------------------------------------------
module comp_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 ready
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  // Upper half is the running partial sum. The lower half starts as the
  // multiplier and is shifted out LSB-first while product bits shift in.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 ready_q, ready_d;

  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   result;
  logic                 last_step;

`ifdef COMP_MULTIPLIER_SIGNED_EN
  logic                 neg_q, neg_d;

  // Magnitudes fit in WIDTH unsigned bits, including the most-negative value
  // (its magnitude 2^(WIDTH-1) is representable unsigned).
  assign op_a   = Multiplicand[WIDTH-1] ? (~Multiplicand + 1'b1) : Multiplicand;
  assign op_b   = Multiplier[WIDTH-1]   ? (~Multiplier + 1'b1)   : Multiplier;
  assign result = neg_q ? (~acc_step + 1'b1) : acc_step;
`else
  assign op_a   = Multiplicand;
  assign op_b   = Multiplier;
  assign result = acc_step;
`endif

  // One shift-add step. The add is WIDTH+1 bits wide so that its carry
  // becomes the new MSB after the right shift.
  assign addend    = acc_q[0] ? mcand_q : '0;
  assign sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign acc_step  = {sum, acc_q[WIDTH-1:1]};
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    ready_d = ready_q;
`ifdef COMP_MULTIPLIER_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (run) begin
          mcand_d = op_a;
          acc_d   = {{WIDTH{1'b0}}, op_b};
          cnt_d   = '0;
`ifdef COMP_MULTIPLIER_SIGNED_EN
          neg_d   = Multiplicand[WIDTH-1] ^ Multiplier[WIDTH-1];
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        // run and the operand inputs are deliberately not looked at here.
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          prod_d  = result;
          ready_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // Holding here while run stays high prevents an automatic restart.
        if (!run) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      ready_q <= 1'b0;
`ifdef COMP_MULTIPLIER_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      ready_q <= ready_d;
`ifdef COMP_MULTIPLIER_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign Product = prod_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_comp_multiplier.sv
module tb_comp_multiplier;

  localparam int WIDTH = 32;

  logic              clk;
  logic              reset;
  logic              run;
  logic [WIDTH-1:0]  Multiplicand;
  logic [WIDTH-1:0]  Multiplier;
  logic [63:0]       Product;
  logic              ready;

  int vectors;
  int miscompares;

  comp_multiplier #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Product      (Product),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply operands and a start edge (DUT must be in IDLE).
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    Multiplicand = a;
    Multiplier   = b;
    run          = 1'b1;
    tick();
  endtask

  // Count edges after the start edge until ready is seen; -1 on timeout.
  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (ready === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run = 1'b0;
    Multiplicand = '0;
    Multiplier = '0;
    tick();
    tick();
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %0b expected 0", ready);
    end
    vectors++;
    if (Product !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_product: got %h expected %h", Product, 64'h0);
    end
    $display("test_reset: ready=%0b Product=%h", ready, Product);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int n;
    start_op(32'h3, 32'h5);
    wait_ready(n);
    vectors++;
    if (n !== WIDTH) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d expected %0d", n, WIDTH);
    end
    vectors++;
    if (Product !== 64'hF) begin
      miscompares++;
      $display("FAIL basic_product: got %h expected %h", Product, 64'hF);
    end
    run = 1'b0;
    tick();
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_ready_drop: got %0b expected 0", ready);
    end
    tick();
    tick();
    vectors++;
    if (Product !== 64'hF) begin
      miscompares++;
      $display("FAIL basic_product_kept: got %h expected %h", Product, 64'hF);
    end
    $display("test_basic: 3 x 5 latency=%0d Product=%h", n, Product);
  endtask

  task automatic test_max();
    int n;
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run = 1'b0;
    wait_ready(n);
    vectors++;
    if (n !== WIDTH) begin
      miscompares++;
      $display("FAIL max_latency: got %0d expected %0d", n, WIDTH);
    end
    vectors++;
    if (Product !== 64'hFFFF_FFFE_0000_0001) begin
      miscompares++;
      $display("FAIL max_product: got %h expected %h", Product, 64'hFFFF_FFFE_0000_0001);
    end
    tick();
    $display("test_max: FFFFFFFF x FFFFFFFF Product=%h", Product);
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses;
    start_op(32'h1234, 32'h5678);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run = 1'b0;
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_ready: got %0b expected 0", ready);
    end
    vectors++;
    if (Product !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_mid_product: got %h expected %h", Product, 64'h0);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_pulse: got %0d ready cycles expected 0", pulses);
    end
    start_op(32'h1234, 32'h5678);
    run = 1'b0;
    wait_ready(n);
    vectors++;
    if (n !== WIDTH) begin
      miscompares++;
      $display("FAIL restart_latency: got %0d expected %0d", n, WIDTH);
    end
    vectors++;
    if (Product !== 64'h0626_0060) begin
      miscompares++;
      $display("FAIL restart_product: got %h expected %h", Product, 64'h0626_0060);
    end
    tick();
    $display("test_reset_mid: pulses=%0d restart latency=%0d Product=%h", pulses, n, Product);
  endtask

  task automatic test_run_held();
    int n;
    int rises;
    int bad_hold;
    logic prev;
    start_op(32'h7, 32'h9);
    wait_ready(n);
    vectors++;
    if (n !== WIDTH) begin
      miscompares++;
      $display("FAIL held_latency: got %0d expected %0d", n, WIDTH);
    end
    vectors++;
    if (Product !== 64'h3F) begin
      miscompares++;
      $display("FAIL held_product: got %h expected %h", Product, 64'h3F);
    end
    rises = (ready === 1'b1) ? 1 : 0;
    prev = ready;
    bad_hold = 0;
    for (int i = n; i < 50; i++) begin
      tick();
      if (ready === 1'b1 && prev !== 1'b1) rises++;
      if (Product !== 64'h3F) bad_hold++;
      prev = ready;
    end
    vectors++;
    if (rises !== 1) begin
      miscompares++;
      $display("FAIL held_single_rise: got %0d rises expected 1", rises);
    end
    vectors++;
    if (bad_hold !== 0) begin
      miscompares++;
      $display("FAIL held_product_stable: got %0d changed cycles expected 0", bad_hold);
    end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL held_ready_high: got %0b expected 1", ready);
    end
    run = 1'b0;
    tick();
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++;
      $display("FAIL held_ready_drop: got %0b expected 0", ready);
    end
    vectors++;
    if (Product !== 64'h3F) begin
      miscompares++;
      $display("FAIL held_product_after_drop: got %h expected %h", Product, 64'h3F);
    end
    $display("test_run_held: 7 x 9 rises=%0d Product=%h", rises, Product);
  endtask

  task automatic test_operand_change();
    int n;
    start_op(32'h2, 32'h2);
    tick();
    tick();
    Multiplicand = 32'hAAAA;
    Multiplier   = 32'h5555;
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    run = 1'b0;
    wait_ready(n);
    vectors++;
    if (n !== WIDTH - 4) begin
      miscompares++;
      $display("FAIL opchg_latency: got %0d expected %0d", n, WIDTH - 4);
    end
    vectors++;
    if (Product !== 64'h4) begin
      miscompares++;
      $display("FAIL opchg_product: got %h expected %h", Product, 64'h4);
    end
    tick();
    $display("test_operand_change: 2 x 2 Product=%h", Product);
  endtask

  task automatic test_zero();
    int n;
    start_op(32'h0, 32'h0001_2345);
    run = 1'b0;
    wait_ready(n);
    vectors++;
    if (n !== WIDTH) begin
      miscompares++;
      $display("FAIL zero_latency: got %0d expected %0d", n, WIDTH);
    end
    vectors++;
    if (Product !== 64'h0) begin
      miscompares++;
      $display("FAIL zero_product: got %h expected %h", Product, 64'h0);
    end
    tick();
    $display("test_zero: 0 x 12345 latency=%0d Product=%h", n, Product);
  endtask

`ifdef COMP_MULTIPLIER_SIGNED_EN
  task automatic test_signed();
    int n;
    start_op(32'hFFFF_FFFD, 32'h0000_0005);
    run = 1'b0;
    wait_ready(n);
    vectors++;
    if (n !== WIDTH) begin
      miscompares++;
      $display("FAIL signed_latency: got %0d expected %0d", n, WIDTH);
    end
    vectors++;
    if (Product !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      miscompares++;
      $display("FAIL signed_neg3x5: got %h expected %h", Product, 64'hFFFF_FFFF_FFFF_FFF1);
    end
    tick();
    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    run = 1'b0;
    wait_ready(n);
    vectors++;
    if (Product !== 64'h0000_0000_8000_0000) begin
      miscompares++;
      $display("FAIL signed_minxneg1: got %h expected %h", Product, 64'h0000_0000_8000_0000);
    end
    tick();
    start_op(32'hFFFF_FFFD, 32'hFFFF_FFFB);
    run = 1'b0;
    wait_ready(n);
    vectors++;
    if (Product !== 64'hF) begin
      miscompares++;
      $display("FAIL signed_neg3xneg5: got %h expected %h", Product, 64'hF);
    end
    tick();
    $display("test_signed: last Product=%h", Product);
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    run = 1'b0;
    Multiplicand = '0;
    Multiplier = '0;
    test_reset();
    test_basic();
`ifndef COMP_MULTIPLIER_SIGNED_EN
    test_max();
`endif
    test_reset_mid();
    test_run_held();
    test_operand_change();
    test_zero();
`ifdef COMP_MULTIPLIER_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/comp_multiplier.md
COMP_MULTIPLIER -- requirements
Module: comp_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; Product is 2*WIDTH bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port run  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port Multiplicand  input  WIDTH  operand A, captured on the start edge.
REQ-006 SHALL have port Multiplier  input  WIDTH  operand B, captured on the start edge.
REQ-007 SHALL have port Product  output  2*WIDTH  registered result, valid while ready=1.
REQ-008 SHALL have port ready  output  1  registered completion flag.

Function
REQ-009 SHALL implement FSM with states IDLE, CALC, DONE; reset state IDLE.
REQ-010 IDLE: on edge with run=1, capture both operands, clear accumulator, set iteration counter to 0, go to CALC.
REQ-011 IDLE with run=0 SHALL hold all registers; Product keeps its last value.
REQ-012 CALC: each edge, add multiplicand to upper accumulator half if current multiplier LSB is 1 (carry kept, WIDTH+1 bit add), then shift the accumulator/multiplier pair right by one.
REQ-013 Counter SHALL be clog2(WIDTH)+1 bits; after the step with counter = WIDTH-1, go to DONE and set ready=1 on that same edge.
REQ-014 Latency SHALL be exactly WIDTH edges (32 by default) from the start edge to the edge that raises ready.
REQ-015 Product SHALL equal the exact 2*WIDTH-bit product on the edge ready rises and SHALL not change while in DONE.
REQ-016 run and operand changes during CALC SHALL be ignored; the operation completes with captured operands.
REQ-017 DONE: hold ready=1 while run=1; on edge with run=0, go to IDLE and clear ready; Product retained.
REQ-018 run held high continuously SHALL NOT retrigger a new operation until run has been seen low in DONE.
REQ-019 Zero operands SHALL take full latency, no early termination.

Reset
REQ-020 reset=1 at an edge SHALL force state IDLE, ready=0, Product=0, counter=0, operand registers=0, from any state.
REQ-021 reset SHALL take priority over run on the same edge; reset mid-CALC aborts the operation with no ready pulse.
REQ-022 After reset releases, the first edge with run=1 SHALL start a new operation normally.

Configuration
REQ-023 Macro COMP_MULTIPLIER_SIGNED_EN SHALL select signed mode when defined.
REQ-024 With COMP_MULTIPLIER_SIGNED_EN defined: operands are two's complement; magnitudes captured at start, unsigned shift-add run, result negated on the DONE-entry edge if operand signs differ; latency unchanged (WIDTH edges).
REQ-025 Without COMP_MULTIPLIER_SIGNED_EN: operands and Product are unsigned; no sign logic present.
REQ-026 Most-negative operand (0x80000000) SHALL produce the correct signed product in signed mode.

Verification
REQ-027 Unsigned: 0x00000003 x 0x00000005, run=1 -> ready rises exactly 32 edges after start, Product=0x000000000000000F.
REQ-028 Unsigned: 0xFFFFFFFF x 0xFFFFFFFF -> Product=0xFFFFFFFE00000001, ready=1.
REQ-029 Reset asserted on 10th CALC edge of 0x1234 x 0x5678 -> next cycle state IDLE, ready=0, Product=0; no ready pulse follows.
REQ-030 run held high 50 cycles after start with 7 x 9 -> single ready rise, Product=0x3F held; dropping run -> ready=0, Product still 0x3F.
REQ-031 Operands changed to 0xAAAA/0x5555 mid-CALC of 2 x 2 -> Product=0x4.
REQ-032 Signed build: 0xFFFFFFFD (-3) x 0x00000005 -> Product=0xFFFFFFFFFFFFFFF1; 0x80000000 x 0xFFFFFFFF -> Product=0x0000000080000000.
